// File: rtl/inst_boot_loader.sv
// inst_boot_loader: receives a program image as a byte stream (header N, then
// 4*N payload bytes), packs little-endian 32-bit words into the instruction ROM
// and holds the core in reset until the image is complete.
// Optional trailing XOR checksum byte: define INST_BOOT_CHECKSUM_EN.
module inst_boot_loader #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 6,
   parameter int DEPTH      = 64
) (
   input  logic                  clk,
   input  logic                  resetIn,
   input  logic                  start,
   input  logic                  byteValid,
   input  logic [7:0]            byteIn,
   output logic                  byteReady,
   output logic                  romWriteEnable,
   output logic [ADDR_WIDTH-1:0] romWriteAddr,
   output logic [DATA_WIDTH-1:0] romWriteData,
   output logic                  coreResetOut,
   output logic                  done,
   output logic                  error,
   output logic [ADDR_WIDTH:0]   wordCount
);

   localparam logic [7:0] DEPTH_B = 8'(DEPTH);

   typedef enum logic [2:0] {
      S_HDR,
      S_LOAD,
      S_WRITE,
      S_RUN,
      S_ERROR
`ifdef INST_BOOT_CHECKSUM_EN
      , S_CHK
`endif
   } state_t;

   state_t              state;
   state_t              next_state;
   logic [1:0]          byte_cnt;
   logic [23:0]         word_buf;
   logic [ADDR_WIDTH:0] n_words;
   logic [ADDR_WIDTH:0] count_inc;
   logic                transfer;
`ifdef INST_BOOT_CHECKSUM_EN
   logic [7:0]          xor_acc;
`endif

   // State register
   always_ff @(posedge clk) begin
      if (!resetIn) state <= S_HDR;
      else          state <= next_state;
   end

   // Next-state decode, byte handshake
   always_comb begin
      next_state = state;
      byteReady  = 1'b0;
      transfer   = 1'b0;
      count_inc  = wordCount + 1'b1;
      case (state)
         S_HDR: begin
            byteReady = 1'b1;
            transfer  = byteValid;
            if (byteValid) begin
               if (byteIn == 8'd0 || byteIn > DEPTH_B) next_state = S_ERROR;
               else                                    next_state = S_LOAD;
            end
         end
         S_LOAD: begin
            byteReady = 1'b1;
            transfer  = byteValid;
            if (byteValid && byte_cnt == 2'd3) next_state = S_WRITE;
         end
         S_WRITE: begin
            if (count_inc == n_words) begin
`ifdef INST_BOOT_CHECKSUM_EN
               next_state = S_CHK;
`else
               next_state = S_RUN;
`endif
            end else begin
               next_state = S_LOAD;
            end
         end
`ifdef INST_BOOT_CHECKSUM_EN
         S_CHK: begin
            byteReady = 1'b1;
            transfer  = byteValid;
            if (byteValid) begin
               if (byteIn == xor_acc) next_state = S_RUN;
               else                   next_state = S_ERROR;
            end
         end
`endif
         S_RUN:   if (start) next_state = S_HDR;
         S_ERROR: if (start) next_state = S_HDR;
         default: next_state = S_HDR;
      endcase
   end

   // Datapath: word assembly, ROM write port, status outputs
   always_ff @(posedge clk) begin
      if (!resetIn) begin
         romWriteEnable <= 1'b0;
         romWriteAddr   <= '0;
         romWriteData   <= '0;
         coreResetOut   <= 1'b1;
         done           <= 1'b0;
         error          <= 1'b0;
         wordCount      <= '0;
         byte_cnt       <= '0;
         word_buf       <= '0;
         n_words        <= '0;
`ifdef INST_BOOT_CHECKSUM_EN
         xor_acc        <= '0;
`endif
      end else begin
         romWriteEnable <= 1'b0;
         coreResetOut   <= 1'b1;
         done           <= 1'b0;
         error          <= (next_state == S_ERROR);
         case (state)
            S_HDR: begin
`ifdef INST_BOOT_CHECKSUM_EN
               xor_acc <= '0;
`endif
               if (transfer && next_state == S_LOAD) n_words <= byteIn[ADDR_WIDTH:0];
            end
            S_LOAD: begin
               if (transfer) begin
                  byte_cnt <= byte_cnt + 2'd1;
`ifdef INST_BOOT_CHECKSUM_EN
                  xor_acc  <= xor_acc ^ byteIn;
`endif
                  case (byte_cnt)
                     2'd0: word_buf[7:0]   <= byteIn;
                     2'd1: word_buf[15:8]  <= byteIn;
                     2'd2: word_buf[23:16] <= byteIn;
                     default: begin
                        // Output registers load on the 4th byte so the strobe
                        // lines up with the WRITE state one cycle later.
                        romWriteEnable <= 1'b1;
                        romWriteAddr   <= wordCount[ADDR_WIDTH-1:0];
                        romWriteData   <= {byteIn, word_buf};
                     end
                  endcase
               end
            end
            S_WRITE: wordCount <= count_inc;
            S_RUN: begin
               if (start) begin
                  wordCount <= '0;
               end else begin
                  coreResetOut <= 1'b0;
                  done         <= 1'b1;
               end
            end
            S_ERROR: if (start) wordCount <= '0;
            default: ;
         endcase
      end
   end

endmodule
